pcpi_matrix_issuer: RTL and testbench
=====================================

# pcpi_matrix_issuer

Initiator-side sequencer for the custom-0 matrix coprocessor on the PCPI bus. A host stages 28 16-bit operands (A, B, bias, threshold) through a simple write port. On `go` the block issues PCPI load instructions, then a start instruction, waits out the computation, captures `pcpi_rd`, and issues a clear. It sits between the test/control logic and the coprocessor, in place of the CPU core's PCPI master.

## Interface
- `TIMEOUT_CYCLES`, 64: maximum cycles spent waiting for compute completion before aborting.
- `clk`  in  1  clock.
- `resetn`  in  1  reset; asynchronous, active-low.
- `cfg_we`  in  1  staging write strobe.
- `cfg_addr`  in  5  staging index. Entries 0–8 are A, 9–17 are B, 18–26 are bias, 27 is threshold. Indices 28–31 are ignored.
- `cfg_data`  in  16  staging value, signed, passed through raw.
- `go`  in  1  run request, sampled in IDLE only.
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle pulse at end of run.
- `err`  out  1  timeout flag; valid with `done`, held until the next `go`.
- `result`  out  32  `pcpi_rd` captured at completion.
- `pcpi_valid`  out  1  instruction valid.
- `pcpi_insn`  out  32  instruction word.
- `pcpi_wr`  in  1  coprocessor write-back flag; unused except for capture qualification.
- `pcpi_rd`  in  32  coprocessor result.
- `pcpi_wait`  in  1  coprocessor busy.
- `pcpi_ready`  in  1  coprocessor accept/complete.

## Operation
- Instruction fields:
  - `[6:0]` = 7'b0001011
  - `[11:7]` = address
  - `[14:12]` = funct3
  - `[30:15]` = value
  - `[31]` = 0
- funct3 codes: 000 = load, 111 = start, 101 = clear.
- For start and clear, address and value are 0.
- Staging: 28×16 registers. Reset value is 0, except entry 27, which resets to -70 (16'hFFBA).
- In IDLE, a write with `cfg_addr` < 28 updates the entry. Writes while `busy` are dropped. A write and `go` in the same cycle: the write lands first and is included in the run.
- FSM states: IDLE, LOAD, GAP, GO, WAIT_BUSY, WAIT_DONE, CLEAR, FINISH.
- IDLE:
  - `go` → LOAD (idx = first entry to issue).
  - `err` clears on `go`.
- LOAD:
  - `pcpi_valid`=1, insn = load(idx, staging[idx]).
  - On a cycle with `pcpi_ready`=1 → GAP.
- GAP:
  - `pcpi_valid`=0 for one cycle.
  - Next entry to issue → LOAD; otherwise → GO.
- GO:
  - `pcpi_valid`=1 with start insn; `pcpi_ready` is ignored in this cycle.
  - → WAIT_BUSY.
- WAIT_BUSY:
  - Start insn is held.
  - `pcpi_wait`=1 → WAIT_DONE.
- WAIT_DONE:
  - Start insn is held.
  - `pcpi_ready`=1 and `pcpi_wait`=0 → latch `result` ← `pcpi_rd` → CLEAR.
- Timeout:
  - A counter runs across WAIT_BUSY and WAIT_DONE.
  - Reaching `TIMEOUT_CYCLES` → `err`=1, `result` unchanged → CLEAR.
- CLEAR: `pcpi_valid`=1 with clear insn for exactly one cycle → FINISH.
- FINISH: `pcpi_valid`=0, `done`=1 → IDLE.
- `busy`=1 in every state except IDLE.

## Timing
- Reset values: `busy`, `done`, `err`, `pcpi_valid` = 0; `result` = 0; `pcpi_insn` = 0.
- Asynchronous reset mid-run drops `pcpi_valid` immediately and returns the FSM to IDLE. Staging entries revert to their reset values.
- `go` sampled at edge T → `busy`=1 and the first load insn are visible after T.
- Each load takes 2 cycles when `pcpi_ready` is held high. A full 28-entry load phase is 56 cycles.
- GO to CLEAR takes ≥3 cycles. `done` asserts exactly 1 cycle after the CLEAR cycle.
- `pcpi_insn` is stable for the whole time `pcpi_valid` is high. It is 0 whenever `pcpi_valid` is 0.
- `go` while `busy` is ignored; there is no queuing.
- If `pcpi_ready` stays low during LOAD, the load is held indefinitely. No timeout applies in LOAD.

## Configuration
- `PCPI_ISSUER_SKIP_CLEAN_EN` defined:
  - Each entry carries a dirty bit, set by reset or by a staging write, and cleared when its load completes.
  - LOAD issues only dirty entries, in ascending index order.
  - If no entry is dirty, the FSM goes IDLE → GO directly, one cycle after `go`.
- Not defined: every run issues all 28 entries, 0..27; there is no dirty logic.

## Test plan
- Reset, stage A = identity, B = 1..9, bias = 0, then `go`, with a responder model (ready high, wait for 8 cycles). Expect:
  - 28 load insns with correct address/value fields, e.g. entry 27 = `{1'b0,16'hFFBA,3'b000,5'd27,7'h0B}`;
  - then start, clear, and `done`;
  - `result` equal to the model's `pcpi_rd`.
- Responder holds `pcpi_ready` low for 5 cycles on load #3. Expect `pcpi_valid` and `pcpi_insn` held constant for those 5 cycles, and no skipped entry.
- Responder never asserts `pcpi_wait`. Expect `err`=1 exactly `TIMEOUT_CYCLES`=64 cycles after the GO cycle, a clear insn issued, `done` pulsed, and `result` unchanged.
- `cfg_we` with addr 27, data 16'h0010, in the same cycle as `go`. Expect the threshold load to carry 0x0010. A write during `busy` to addr 0 leaves staging[0] unchanged.
- Assert `resetn` low during WAIT_DONE. Expect `pcpi_valid`=0 without waiting for a clock edge, with `busy`=0 and `done`=0.
- With `PCPI_ISSUER_SKIP_CLEAN_EN` defined: run once, write only entry 4, run again. Expect exactly one load insn (address 4) in the second run. A third run with no writes goes straight to start.

Source files
------------

// File: rtl/pcpi_matrix_issuer.sv
// PCPI initiator that stages 28 matrix operands, issues load/start/clear instructions to the custom-0 coprocessor.
// Define PCPI_ISSUER_SKIP_CLEAN_EN to reload only entries written since their last successful load.
module pcpi_matrix_issuer #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cfg_we,
    input  logic [4:0]  cfg_addr,
    input  logic [15:0] cfg_data,
    input  logic        go,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] result,
    output logic        pcpi_valid,
    output logic [31:0] pcpi_insn,
    input  logic        pcpi_wr,
    input  logic [31:0] pcpi_rd,
    input  logic        pcpi_wait,
    input  logic        pcpi_ready
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOAD      = 3'd1;
    localparam logic [2:0] S_GAP       = 3'd2;
    localparam logic [2:0] S_GO        = 3'd3;
    localparam logic [2:0] S_WAIT_BUSY = 3'd4;
    localparam logic [2:0] S_WAIT_DONE = 3'd5;
    localparam logic [2:0] S_CLEAR     = 3'd6;
    localparam logic [2:0] S_FINISH    = 3'd7;

    localparam logic [6:0] OPCODE  = 7'b0001011;
    localparam logic [2:0] F_LOAD  = 3'b000;
    localparam logic [2:0] F_START = 3'b111;
    localparam logic [2:0] F_CLEAR = 3'b101;

    localparam int unsigned        CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]       state;
    logic [4:0]       idx;
    logic [CNT_W-1:0] cnt;
    logic [15:0]      stage [28];
    logic             cfg_hit;
    logic [5:0]       start_pick;   // {valid, index}
    logic [5:0]       next_pick;

    assign cfg_hit = cfg_we && (state == S_IDLE) && (cfg_addr < 5'd28);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < 28; i++)
                stage[i] <= (i == 27) ? 16'hFFBA : '0;
        end else if (cfg_hit) begin
            stage[cfg_addr] <= cfg_data;
        end
    end

`ifdef PCPI_ISSUER_SKIP_CLEAN_EN
    logic [27:0] dirty;
    logic [27:0] wr_mask;

    function automatic logic [5:0] first_set(input logic [27:0] m);
        logic [5:0] r;
        r = '0;
        for (int unsigned i = 0; i < 28; i++)
            if (m[i] && !r[5]) r = {1'b1, 5'(i)};
        return r;
    endfunction

    always_comb begin
        wr_mask = '0;
        if (cfg_hit) wr_mask[cfg_addr] = 1'b1;
    end

    // The just-loaded entry is already clean in GAP, so the lowest dirty bit is the next one up.
    assign start_pick = first_set(dirty | wr_mask);
    assign next_pick  = first_set(dirty);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dirty <= '1;
        end else begin
            if (cfg_hit) dirty[cfg_addr] <= 1'b1;
            if (state == S_LOAD && pcpi_ready) dirty[idx] <= 1'b0;
        end
    end
`else
    assign start_pick = {1'b1, 5'd0};
    assign next_pick  = (idx == 5'd27) ? 6'd0 : {1'b1, idx + 5'd1};
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= S_IDLE;
            idx    <= '0;
            cnt    <= '0;
            err    <= 1'b0;
            result <= '0;
        end else begin
            case (state)
                S_IDLE: if (go) begin
                    err <= 1'b0;
                    if (start_pick[5]) begin
                        idx   <= start_pick[4:0];
                        state <= S_LOAD;
                    end else begin
                        state <= S_GO;
                    end
                end
                S_LOAD: if (pcpi_ready) state <= S_GAP;
                S_GAP: begin
                    if (next_pick[5]) begin
                        idx   <= next_pick[4:0];
                        state <= S_LOAD;
                    end else begin
                        state <= S_GO;
                    end
                end
                S_GO: begin
                    cnt   <= CNT_W'(1);
                    state <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY, S_WAIT_DONE: begin
                    // cnt equals the number of cycles elapsed since the GO cycle
                    if (state == S_WAIT_DONE && pcpi_ready && !pcpi_wait) begin
                        if (pcpi_wr) result <= pcpi_rd;
                        state <= S_CLEAR;
                    end else if (cnt >= CNT_LAST) begin
                        err   <= 1'b1;
                        state <= S_CLEAR;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                        if (state == S_WAIT_BUSY && pcpi_wait) state <= S_WAIT_DONE;
                    end
                end
                S_CLEAR:  state <= S_FINISH;
                S_FINISH: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        pcpi_valid = 1'b0;
        pcpi_insn  = '0;
        case (state)
            S_LOAD: begin
                pcpi_valid = 1'b1;
                pcpi_insn  = {1'b0, stage[idx], F_LOAD, idx, OPCODE};
            end
            S_GO, S_WAIT_BUSY, S_WAIT_DONE: begin
                pcpi_valid = 1'b1;
                pcpi_insn  = {1'b0, 16'h0000, F_START, 5'd0, OPCODE};
            end
            S_CLEAR: begin
                pcpi_valid = 1'b1;
                pcpi_insn  = {1'b0, 16'h0000, F_CLEAR, 5'd0, OPCODE};
            end
            default: ;
        endcase
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_FINISH);

endmodule

// File: tb/tb_pcpi_matrix_issuer.sv
// Scoreboard bench for pcpi_matrix_issuer with a PCPI responder model; honours PCPI_ISSUER_SKIP_CLEAN_EN.
module tb_pcpi_matrix_issuer;

    localparam int unsigned TO = 64;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        cfg_we = 1'b0;
    logic [4:0]  cfg_addr = '0;
    logic [15:0] cfg_data = '0;
    logic        go = 1'b0;
    logic        busy, done, err, pcpi_valid;
    logic [31:0] result, pcpi_insn;
    logic        pcpi_wr = 1'b0;
    logic [31:0] pcpi_rd = '0;
    logic        pcpi_wait = 1'b0;
    logic        pcpi_ready = 1'b0;

    always #5 clk = ~clk;

    pcpi_matrix_issuer #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .resetn(resetn), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .go(go), .busy(busy), .done(done), .err(err), .result(result),
        .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn), .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd),
        .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready)
    );

    localparam logic [31:0] START = {1'b0, 16'h0000, 3'b111, 5'd0, 7'h0B};
    localparam logic [31:0] CLR   = {1'b0, 16'h0000, 3'b101, 5'd0, 7'h0B};

    int checks = 0;
    int fails = 0;
    logic [31:0] exp_insn [$];
    logic [32:0] exp_done [$];   // {err, result}
    logic [15:0] model [28];
    logic [31:0] last_result = '0;
    int          burst_len [28];
    int          load_no = 0;
`ifdef PCPI_ISSUER_SKIP_CLEAN_EN
    logic [27:0] tb_dirty = '1;
`endif

    // responder controls
    int          resp_mode = 0;      // 0: normal, 1: never raises pcpi_wait
    int          stall_load = 0;     // 1-based load number to stall, 0 = none
    int          stall_len = 0;
    logic [31:0] resp_rd = '0;

    function automatic logic [31:0] mk_load(input logic [4:0] a, input logic [15:0] v);
        return {1'b0, v, 3'b000, a, 7'b0001011};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 28; i++) model[i] = (i == 27) ? 16'hFFBA : 16'h0000;
        last_result = '0;
`ifdef PCPI_ISSUER_SKIP_CLEAN_EN
        tb_dirty = '1;
`endif
    endtask

    task automatic wr(input logic [4:0] a, input logic [15:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        @(posedge clk); #2;
        cfg_we = 1'b0;
        if (a < 5'd28) begin
            model[a] = d;
`ifdef PCPI_ISSUER_SKIP_CLEAN_EN
            tb_dirty[a] = 1'b1;
`endif
        end
    endtask

    task automatic push_run(input logic [31:0] rd, input logic exp_err);
        for (int i = 0; i < 28; i++) begin
`ifdef PCPI_ISSUER_SKIP_CLEAN_EN
            if (tb_dirty[i]) exp_insn.push_back(mk_load(5'(i), model[i]));
`else
            exp_insn.push_back(mk_load(5'(i), model[i]));
`endif
        end
`ifdef PCPI_ISSUER_SKIP_CLEAN_EN
        tb_dirty = '0;
`endif
        exp_insn.push_back(START);
        exp_insn.push_back(CLR);
        if (!exp_err) last_result = rd;
        exp_done.push_back({exp_err, last_result});
        resp_rd = rd;
        load_no = 0;
    endtask

    task automatic pulse_go();
        go = 1'b1;
        @(posedge clk); #2;
        go = 1'b0;
    endtask

    task automatic wait_start(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(pcpi_valid && pcpi_insn == START) && n < 500);
        if (n >= 500) chk("start_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (busy && k < 500);
        chk("idle_reached", busy, 0);
    endtask

    // PCPI responder: drives handshake shortly after each rising edge
    initial begin : responder
        int   loads;
        int   stall_left;
        int   start_cyc;
        logic pv;
        logic [31:0] pi;
        loads = 0; stall_left = 0; start_cyc = 0; pv = 1'b0; pi = '0;
        forever begin
            @(posedge clk); #1;
            if (!resetn || !busy) loads = 0;
            pcpi_ready = 1'b0; pcpi_wait = 1'b0; pcpi_wr = 1'b0;
            if (pcpi_valid && pcpi_insn[14:12] == 3'b000) begin
                if (!pv || pi != pcpi_insn) begin
                    loads++;
                    stall_left = (loads == stall_load) ? stall_len : 0;
                end
                if (stall_left > 0) stall_left--;
                else pcpi_ready = 1'b1;
            end else if (pcpi_valid && pcpi_insn[14:12] == 3'b111 && resp_mode == 0) begin
                start_cyc++;
                if (start_cyc <= 8) pcpi_wait = 1'b1;
                else begin
                    pcpi_ready = 1'b1; pcpi_wr = 1'b1; pcpi_rd = resp_rd;
                end
            end
            if (!(pcpi_valid && pcpi_insn[14:12] == 3'b111)) start_cyc = 0;
            pv = pcpi_valid; pi = pcpi_insn;
        end
    end

    // monitor: pops the scoreboard on each new instruction and on each done pulse
    initial begin : monitor
        logic pv;
        logic pd;
        logic [31:0] pi;
        int len;
        logic [32:0] e;
        pv = 1'b0; pd = 1'b0; pi = '0; len = 0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                pv = 1'b0; pd = 1'b0; pi = '0; len = 0;
                continue;
            end
            if (pv && pi[14:12] == 3'b000 && !(pcpi_valid && pcpi_insn == pi)) begin
                if (load_no < 28) burst_len[load_no] = len;
                load_no++;
            end
            if (pcpi_valid && (!pv || pcpi_insn != pi)) begin
                if (exp_insn.size() == 0) chk("insn_unexpected", pcpi_insn, 0);
                else chk("insn", pcpi_insn, exp_insn.pop_front());
            end
            if (pcpi_valid && pcpi_insn[14:12] == 3'b000)
                len = (pv && pcpi_insn == pi) ? len + 1 : 1;
            if (!pcpi_valid && busy) chk("insn_zero_when_idle_bus", pcpi_insn, 0);
            if (done) begin
                chk("done_single_cycle", pd, 0);
                chk("clear_before_done", (pv && pi == CLR), 1);
                if (exp_done.size() == 0) chk("done_unexpected", 1, 0);
                else begin
                    e = exp_done.pop_front();
                    chk("err", err, e[32]);
                    chk("result", result, e[31:0]);
                end
            end
            pv = pcpi_valid; pi = pcpi_insn; pd = done;
        end
    end

    initial begin : stimulus
        int n;
        int k;
        model_reset();

        // reset values
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_valid", pcpi_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_insn", pcpi_insn, 0);
        #1 resetn = 1'b1;
        @(posedge clk); #2;

        // run 1: A = identity, B = 1..9, bias = 0
        for (int i = 0; i < 9; i++) wr(5'(i), (i == 0 || i == 4 || i == 8) ? 16'h0001 : 16'h0000);
        for (int i = 0; i < 9; i++) wr(5'(9 + i), 16'(i + 1));
        for (int i = 18; i < 27; i++) wr(5'(i), 16'h0000);
        push_run(32'h0000_1234, 1'b0);
        pulse_go();
        wait_start(n);
        chk("load_phase_cycles", n, 57);   // 28 loads x 2 cycles, start seen on the next cycle
        wait_idle();
        chk("burst_len_0", burst_len[0], 1);

        // run 2: responder stalls load #3 for 5 cycles
        for (int i = 0; i < 9; i++) wr(5'(9 + i), 16'(i + 10));
        stall_load = 3; stall_len = 5;
        push_run(32'hCAFE_0002, 1'b0);
        pulse_go();
        wait_idle();
        chk("stall_burst_len", burst_len[2], 6);
        chk("after_stall_burst_len", burst_len[3], 1);
        stall_load = 0;

        // run 3: no pcpi_wait ever, timeout expected
        resp_mode = 1;
        push_run(32'hBAD0_BAD0, 1'b1);
        pulse_go();
        wait_start(n);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!err && k < 200);
        chk("timeout_cycles", k, 64);
        wait_idle();
        chk("err_held", err, 1);
        resp_mode = 0;

        // run 4: threshold write in the same cycle as go, then a dropped write while busy
        model[27] = 16'h0010;
`ifdef PCPI_ISSUER_SKIP_CLEAN_EN
        tb_dirty[27] = 1'b1;
`endif
        push_run(32'h0000_0BEE, 1'b0);
        cfg_we = 1'b1; cfg_addr = 5'd27; cfg_data = 16'h0010;
        pulse_go();
        cfg_we = 1'b0;
        @(negedge clk); #1;
        cfg_we = 1'b1; cfg_addr = 5'd0; cfg_data = 16'h7777;
        @(posedge clk); #2;
        cfg_we = 1'b0;
        wait_idle();
        chk("err_cleared", err, 0);

        // run 5: entry 0 must still hold its pre-busy value
        push_run(32'h5555_0005, 1'b0);
        pulse_go();
        wait_idle();

        // run 6: asynchronous reset during WAIT_DONE
        for (int i = 0; i < 3; i++) wr(5'(9 + i), 16'h00AA);
        push_run(32'h0000_0666, 1'b0);
        pulse_go();
        wait_start(n);
        repeat (4) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("areset_valid", pcpi_valid, 0);
        chk("areset_busy", busy, 0);
        chk("areset_done", done, 0);
        chk("areset_result", result, 0);
        exp_insn.delete();
        exp_done.delete();
        model_reset();
        repeat (2) @(negedge clk);
        #1 resetn = 1'b1;
        @(posedge clk); #2;

        // run 7: staging back to reset defaults (threshold 16'hFFBA)
        push_run(32'h0000_0007, 1'b0);
        pulse_go();
        wait_idle();

`ifdef PCPI_ISSUER_SKIP_CLEAN_EN
        // only the rewritten entry is reloaded, then nothing at all
        wr(5'd4, 16'h0044);
        push_run(32'h0000_0008, 1'b0);
        pulse_go();
        wait_idle();
        chk("skip_single_load", load_no, 1);
        push_run(32'h0000_0009, 1'b0);
        pulse_go();
        wait_start(n);
        chk("skip_direct_start", n, 1);
        wait_idle();
`endif

        repeat (3) @(negedge clk);
        chk("insn_queue_drained", exp_insn.size(), 0);
        chk("done_queue_drained", exp_done.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
